// File: rtl/ca_code_correlator_if.sv
// Chip-stream and status bundle between the front-end sampler and the C/A correlator.
// The master drives the received chips; the slave (correlator) reports phase, correlation and state.
interface ca_code_correlator_if;
  logic        en;
  logic        chip_stb;
  logic        chip_in;
  logic [9:0]  code_phase;
  logic [10:0] corr;
  logic        corr_vld;
  logic        epoch;
  logic [1:0]  state;
  logic        locked;

  modport master (
    output en, chip_stb, chip_in,
    input  code_phase, corr, corr_vld, epoch, state, locked
  );

  modport slave (
    input  en, chip_stb, chip_in,
    output code_phase, corr, corr_vld, epoch, state, locked
  );
endinterface

// File: rtl/ca_code_correlator.sv
// Serial-search C/A code acquisition: regenerates the local Gold code, correlates it per period
// against hard-decision chips, slips one chip per failed period and monitors lock.
module ca_code_correlator #(
  parameter int unsigned T0       = 2,
  parameter int unsigned T1       = 6,
  parameter int unsigned THRESH   = 700,
  parameter int unsigned MISS_MAX = 3
) (
  input logic                    clk,
  input logic                    rst,
  ca_code_correlator_if.slave    bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StVerify = 2'd2,
    StLock   = 2'd3
  } state_e;

  localparam int unsigned      MissW   = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);
  localparam logic [10:0]      Thresh  = 11'(THRESH);
  localparam logic [MissW-1:0] MissMax = MissW'(MISS_MAX);

  state_e            state_q, state_d;
  logic [10:1]       g1_q, g1_d, g2_q, g2_d;
  logic [9:0]        acc_q, acc_d;
  logic [9:0]        phase_q, phase_d;
  logic [10:0]       corr_q, corr_d;
  logic              vld_q, vld_d;
  logic              slip_q, slip_d;
  logic [MissW-1:0]  miss_q, miss_d;

  logic              local_chip;
  logic              agree;
  logic              accept;
  logic              last;
  logic              hit;
  logic [10:0]       corr_new;
  logic [MissW-1:0]  miss_inc;

  assign local_chip = g1_q[10] ^ g2_q[T0] ^ g2_q[T1];
  assign agree      = ~(bus.chip_in ^ local_chip);
  assign accept     = bus.en && bus.chip_stb && (state_q != StIdle);
  assign last       = (phase_q == 10'd1022);
  assign corr_new   = {1'b0, acc_q} + {10'd0, agree};
  assign hit        = (corr_new >= Thresh);
  assign miss_inc   = miss_q + MissW'(1);

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      g1_q    <= '1;
      g2_q    <= '1;
      acc_q   <= '0;
      phase_q <= '0;
      corr_q  <= '0;
      vld_q   <= 1'b0;
      slip_q  <= 1'b0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      acc_q   <= acc_d;
      phase_q <= phase_d;
      corr_q  <= corr_d;
      vld_q   <= vld_d;
      slip_q  <= slip_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state: en low dominates everything, a pending slip swallows exactly one strobe
  always_comb begin
    state_d = state_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    corr_d  = corr_q;
    vld_d   = 1'b0;
    slip_d  = slip_q;
    miss_d  = miss_q;
    if (!bus.en) begin
      state_d = StIdle;
      g1_d    = '1;
      g2_d    = '1;
      acc_d   = '0;
      phase_d = '0;
      slip_d  = 1'b0;
      miss_d  = '0;
    end else if (state_q == StIdle) begin
      state_d = StSearch;
    end else if (accept && slip_q) begin
      slip_d = 1'b0;
    end else if (accept) begin
      g1_d    = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
      g2_d    = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
      acc_d   = acc_q + {9'd0, agree};
      phase_d = phase_q + 10'd1;
      if (last) begin
        // Reload forces an exact 1023-chip period
        g1_d    = '1;
        g2_d    = '1;
        acc_d   = '0;
        phase_d = '0;
        corr_d  = corr_new;
        vld_d   = 1'b1;
        unique case (state_q)
          StSearch: begin
            if (hit) state_d = StVerify;
            else     slip_d  = 1'b1;
          end
          StVerify: begin
            if (hit) begin
              state_d = StLock;
            end else begin
              state_d = StSearch;
              slip_d  = 1'b1;
            end
          end
          StLock: begin
            if (hit) begin
              miss_d = '0;
            end else if (miss_inc == MissMax) begin
              state_d = StSearch;
              slip_d  = 1'b1;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    bus.code_phase = phase_q;
    bus.corr       = corr_q;
    bus.corr_vld   = vld_q;
    bus.epoch      = vld_q;
    bus.state      = state_q;
    bus.locked     = (state_q == StLock);
  end

endmodule

// File: tb/tb_ca_code_correlator.sv
// Directed bench for ca_code_correlator: PRN1 reference from the G1/G2 recurrences,
// one task per scenario with inline expected values.
module tb_ca_code_correlator;
  logic clk = 1'b0;
  logic rst;

  ca_code_correlator_if bus ();

  ca_code_correlator #(
    .T0       (2),
    .T1       (6),
    .THRESH   (700),
    .MISS_MAX (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit code [1023];
  bit s1   [1033];
  bit s2   [1033];
  int zeros;

  int k;
  int offset;
  bit force0;

  logic        s_vld, s_epoch, s_locked;
  logic [10:0] s_corr;
  logic [1:0]  s_state;
  logic [9:0]  s_phase;
  int          s_cyc;

  // PRN1 = G1 output ^ G2 taps 2,6 expressed as sequence offsets (+8, +4)
  task automatic build_code();
    for (int i = 0; i < 10; i++) begin
      s1[i] = 1'b1;
      s2[i] = 1'b1;
    end
    zeros = 0;
    for (int n = 0; n < 1023; n++) begin
      s1[n+10] = s1[n+7] ^ s1[n];
      s2[n+10] = s2[n+8] ^ s2[n+7] ^ s2[n+4] ^ s2[n+2] ^ s2[n+1] ^ s2[n];
    end
    for (int n = 0; n < 1023; n++) begin
      code[n] = s1[n] ^ s2[n+8] ^ s2[n+4];
      if (!code[n]) zeros++;
    end
  endtask

  task automatic sample();
    s_vld    = bus.corr_vld;
    s_epoch  = bus.epoch;
    s_locked = bus.locked;
    s_corr   = bus.corr;
    s_state  = bus.state;
    s_phase  = bus.code_phase;
    s_cyc    = cyc;
  endtask

  task automatic send_chip(input int gap);
    int idx;
    idx = (k - offset) % 1023;
    if (idx < 0) idx += 1023;
    bus.chip_in  = force0 ? 1'b0 : code[idx];
    bus.chip_stb = 1'b1;
    @(posedge clk); #1;
    bus.chip_stb = 1'b0;
    k++;
    sample();
    for (int g = 1; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_period(input int gap, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1100 && !ok; i++) begin
      send_chip(gap);
      if (s_vld) ok = 1'b1;
    end
  endtask

  task automatic restart(input int off);
    bus.en = 1'b0;
    force0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    offset = off;
    k      = 0;
    bus.en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    sample();
    checks++;
    if ({s_phase, s_corr, s_vld, s_epoch, s_state, s_locked} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got phase=%0d corr=%0d vld=%0b epoch=%0b state=%0d locked=%0b expected all 0",
               s_phase, s_corr, s_vld, s_epoch, s_state, s_locked);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    sample();
    checks++;
    if (s_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle_en0: got state=%0d expected 0", s_state);
    end
  endtask

  task automatic test_zero_offset();
    bit ok;
    restart(0);
    send_chip(4);
    checks++;
    if (s_phase !== 10'd1) begin
      errors++;
      $display("FAIL zero_first_phase: got %0d expected 1", s_phase);
    end
    wait_period(4, ok);
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd2 || s_locked !== 1'b0 || s_epoch !== 1'b1) begin
      errors++;
      $display("FAIL zero_p1: got ok=%0b corr=%0d state=%0d locked=%0b epoch=%0b expected 1 1023 2 0 1",
               ok, s_corr, s_state, s_locked, s_epoch);
    end
    wait_period(4, ok);
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd3 || s_locked !== 1'b1) begin
      errors++;
      $display("FAIL zero_p2: got ok=%0b corr=%0d state=%0d locked=%0b expected 1 1023 3 1",
               ok, s_corr, s_state, s_locked);
    end
  endtask

  task automatic test_lag5();
    bit ok;
    restart(5);
    for (int p = 1; p <= 5; p++) begin
      wait_period(1, ok);
      checks++;
      if (!ok || !(s_corr == 11'd479 || s_corr == 11'd511 || s_corr == 11'd543) || s_state !== 2'd1) begin
        errors++;
        $display("FAIL lag5_p%0d: got ok=%0b corr=%0d state=%0d expected corr in {479,511,543} state 1",
                 p, ok, s_corr, s_state);
      end
    end
    wait_period(1, ok);
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd2) begin
      errors++;
      $display("FAIL lag5_p6: got ok=%0b corr=%0d state=%0d expected 1023 2", ok, s_corr, s_state);
    end
    wait_period(1, ok);
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd3) begin
      errors++;
      $display("FAIL lag5_p7: got ok=%0b corr=%0d state=%0d expected 1023 3", ok, s_corr, s_state);
    end
  endtask

  task automatic test_lock_loss();
    bit ok;
    bit [1:0] exp_st [3];
    exp_st[0] = 2'd3;
    exp_st[1] = 2'd3;
    exp_st[2] = 2'd1;
    restart(0);
    wait_period(1, ok);
    wait_period(1, ok);
    checks++;
    if (!ok || s_state !== 2'd3) begin
      errors++;
      $display("FAIL loss_lock: got ok=%0b state=%0d expected 1 3", ok, s_state);
    end
    force0 = 1'b1;
    for (int p = 0; p < 2; p++) begin
      wait_period(1, ok);
      checks++;
      if (!ok || s_corr !== 11'(zeros) || s_state !== 2'd3) begin
        errors++;
        $display("FAIL loss_miss%0d: got ok=%0b corr=%0d state=%0d expected 1 %0d 3",
                 p, ok, s_corr, s_state, zeros);
      end
    end
    force0 = 1'b0;
    wait_period(1, ok);
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd3) begin
      errors++;
      $display("FAIL loss_restore: got ok=%0b corr=%0d state=%0d expected 1 1023 3", ok, s_corr, s_state);
    end
    force0 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      wait_period(1, ok);
      checks++;
      if (!ok || s_state !== exp_st[p] || s_phase !== 10'd0) begin
        errors++;
        $display("FAIL loss_drop%0d: got ok=%0b state=%0d phase=%0d expected 1 %0d 0",
                 p, ok, s_state, s_phase, exp_st[p]);
      end
    end
    force0 = 1'b0;
    send_chip(1);
    checks++;
    if (s_phase !== 10'd0) begin
      errors++;
      $display("FAIL loss_slip_discard: got phase=%0d expected 0", s_phase);
    end
    send_chip(1);
    checks++;
    if (s_phase !== 10'd1) begin
      errors++;
      $display("FAIL loss_after_slip: got phase=%0d expected 1", s_phase);
    end
  endtask

  task automatic test_enable_drop();
    restart(0);
    for (int i = 0; i < 400; i++) send_chip(1);
    checks++;
    if (s_phase !== 10'd400) begin
      errors++;
      $display("FAIL en_phase400: got %0d expected 400", s_phase);
    end
    bus.en = 1'b0;
    send_chip(1);
    checks++;
    if (s_state !== 2'd0 || s_phase !== 10'd0 || s_vld !== 1'b0) begin
      errors++;
      $display("FAIL en_drop: got state=%0d phase=%0d vld=%0b expected 0 0 0", s_state, s_phase, s_vld);
    end
    for (int i = 0; i < 3; i++) begin
      send_chip(1);
      checks++;
      if (s_state !== 2'd0 || s_phase !== 10'd0 || s_vld !== 1'b0) begin
        errors++;
        $display("FAIL en_low_stb%0d: got state=%0d phase=%0d vld=%0b expected 0 0 0",
                 i, s_state, s_phase, s_vld);
      end
    end
    restart(0);
    for (int i = 0; i < 1022; i++) send_chip(1);
    checks++;
    if (s_phase !== 10'd1022) begin
      errors++;
      $display("FAIL en_phase1022: got %0d expected 1022", s_phase);
    end
    bus.en = 1'b0;
    send_chip(1);
    checks++;
    if (s_vld !== 1'b0 || s_state !== 2'd0 || s_phase !== 10'd0) begin
      errors++;
      $display("FAIL en_drop_period_end: got vld=%0b state=%0d phase=%0d expected 0 0 0",
               s_vld, s_state, s_phase);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    restart(0);
    wait_period(1, ok);
    wait_period(1, ok);
    checks++;
    if (!ok || s_state !== 2'd3) begin
      errors++;
      $display("FAIL areset_lock: got ok=%0b state=%0d expected 1 3", ok, s_state);
    end
    for (int i = 0; i < 300; i++) send_chip(1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    sample();
    checks++;
    if ({s_phase, s_corr, s_vld, s_epoch, s_state, s_locked} !== 26'd0) begin
      errors++;
      $display("FAIL areset_async: got phase=%0d corr=%0d vld=%0b epoch=%0b state=%0d locked=%0b expected all 0",
               s_phase, s_corr, s_vld, s_epoch, s_state, s_locked);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    k      = 0;
    offset = 0;
    wait_period(1, ok);
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd2) begin
      errors++;
      $display("FAIL areset_p1: got ok=%0b corr=%0d state=%0d expected 1 1023 2", ok, s_corr, s_state);
    end
    wait_period(1, ok);
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd3 || s_locked !== 1'b1) begin
      errors++;
      $display("FAIL areset_p2: got ok=%0b corr=%0d state=%0d locked=%0b expected 1 1023 3 1",
               ok, s_corr, s_state, s_locked);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c1;
    restart(0);
    wait_period(1, ok);
    c1 = s_cyc;
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd2) begin
      errors++;
      $display("FAIL b2b_p1: got ok=%0b corr=%0d state=%0d expected 1 1023 2", ok, s_corr, s_state);
    end
    wait_period(1, ok);
    checks++;
    if (!ok || s_corr !== 11'd1023 || s_state !== 2'd3) begin
      errors++;
      $display("FAIL b2b_p2: got ok=%0b corr=%0d state=%0d expected 1 1023 3", ok, s_corr, s_state);
    end
    checks++;
    if (s_cyc - c1 != 1023) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles expected 1023", s_cyc - c1);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.chip_stb = 1'b0;
    bus.chip_in  = 1'b0;
    force0       = 1'b0;
    offset       = 0;
    k            = 0;
    build_code();
    test_reset();
    test_zero_offset();
    test_lag5();
    test_lock_loss();
    test_enable_drop();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish before 2000000 ns");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

// File: doc/ca_code_correlator.md
# ca_code_correlator

Serial-search acquisition and lock monitor for one GPS C/A code (PRN). It is the receive-side counterpart of the C/A code generator. It regenerates the local Gold-code replica and correlates it chip-by-chip against a hard-decision received chip stream, accumulating over one 1023-chip code period. The local code phase is slipped one chip per failed period until correlation crosses a threshold, after which lock is verified and monitored. It sits between the front-end sampler / NCO chip strobe and the tracking / LED status logic.

## Interface
- `T0`, default 2: first G2 tap (1-based, ICD convention) for the PRN phase selector; 2 selects PRN1.
- `T1`, default 6: second G2 tap (1-based); 6 selects PRN1.
- `THRESH`, default 700: minimum agreement count (of 1023) that counts as a hit.
- `MISS_MAX`, default 3: number of consecutive failing periods in LOCK before lock is dropped.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  search enable; while low, the block is held in IDLE.
- `chip_stb`  in  1  one-cycle pulse, one per received chip.
- `chip_in`  in  1  received chip, valid when `chip_stb` = 1.
- `code_phase`  out  10  index 0..1022 of the local chip that the next `chip_stb` consumes.
- `corr`  out  11  agreement count of the last completed period.
- `corr_vld`  out  1  one-cycle pulse when `corr` updates.
- `epoch`  out  1  one-cycle pulse at local code wrap; coincident with `corr_vld`.
- `state`  out  2  IDLE=0, SEARCH=1, VERIFY=2, LOCK=3.
- `locked`  out  1  high when `state` = LOCK.

## Operation
- **Local replica**
  - G1 = 1+x^3+x^10; G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10.
  - Both registers initialise to all ones.
  - Local chip = G1[10] ^ G2[T0] ^ G2[T1].
  - The replica advances once per accepted `chip_stb`.
  - On the stb that consumes index 1022, `code_phase` returns to 0 and both G1 and G2 reload to all ones, forcing an exact 1023 period.
- **Accumulator (10 bits)**
  - On each accepted stb: acc += ~(chip_in ^ local).
  - On the stb that consumes index 1022: `corr` <= acc + that chip's agreement (0..1023), acc <= 0, `corr_vld`/`epoch` pulse.
- **Slip**
  - When a slip is pending, the next `chip_stb` is discarded: no accumulation, no generator advance, `code_phase` unchanged. The pending flag then clears.
  - This delays the replica by one chip relative to the input.
  - Slip count wraps freely; the search never terminates on its own.
- **State machine** (decisions are evaluated on the period-end edge)
  - IDLE: generator held at reset state, acc = 0, miss = 0, slip pending = 0. en=1 moves to SEARCH on the next edge.
  - SEARCH: corr ≥ THRESH → VERIFY. Otherwise set slip pending and stay in SEARCH.
  - VERIFY: the next full period runs with no slip. corr ≥ THRESH → LOCK. Otherwise set slip pending and return to SEARCH.
  - LOCK: corr ≥ THRESH clears miss. corr < THRESH increments miss. When miss reaches MISS_MAX → SEARCH with slip pending and miss cleared.
  - en=0 in any state → IDLE on the next edge. IDLE clears generator, acc, miss, slip pending and `code_phase`.
- **Simultaneous events**
  - en falling together with `chip_stb`: IDLE wins and the chip is ignored.
  - en falling on the period-end stb: no `corr_vld`.

## Timing
- Reset values: `code_phase`=0, `corr`=0, `corr_vld`=0, `epoch`=0, `state`=0, `locked`=0. Internal G1, G2, acc, miss and slip flag are also cleared.
- `rst` takes effect immediately, without a clock edge, including mid-period. The first period after release starts at index 0.
- Inputs are sampled at the rising edge. `chip_stb` may be high on consecutive cycles; the maximum rate is one chip per clock.
- `corr`, `corr_vld`, `epoch`, `state` and `locked` all update on the same edge that registers the period-end stb (1 cycle latency from stb).
- `code_phase` updates on the edge that registers the stb.

## Test plan
- **Zero offset:** chip_in = PRN1 reference sequence from index 0, stb every 4 cycles, en=1 → corr=1023 at each `corr_vld`; state SEARCH→VERIFY after period 1, LOCK after period 2; `locked`=1 at the 2nd `corr_vld`.
- **Input lagging 5 chips:** chip_in[n] = code[n−5] → five periods with corr ∈ {479,511,543} and state SEARCH; period 6 gives 1023 → VERIFY; period 7 gives 1023 → LOCK.
- **Lock loss:** locked, then chip_in forced to 0 for 2 periods and the correct code restored → stays LOCK, miss clears. Forced to 0 for 3 periods → state=1 at the 3rd `corr_vld`, and the following stb is discarded (`code_phase` unchanged).
- **Enable drop:** en=0 at `code_phase`=400 → next edge gives state=0 and `code_phase`=0. No `corr_vld` is produced, and stbs are ignored while en=0.
- **Async reset:** `rst` pulsed between clock edges mid-period in LOCK → all outputs 0 before the next edge. After release with the zero-offset stimulus, the block relocks per the zero-offset test.
- **Back-to-back strobes:** stb every cycle with the zero-offset stimulus → identical `corr`/state sequence to the zero-offset test; `corr_vld` 1023 cycles apart.
